// File: rtl/kamus_pkg.sv
// Shared types and constants for the kamus instruction-fetch front end.
package kamus_pkg;

  typedef enum logic [1:0] {
    BOOT_ST,
    RUN_ST,
    DRAIN_ST
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/kamus_fetch_fifo.sv
// Synchronous prefetch FIFO; write-to-head-visible latency 1 cycle, pop gated by non-empty.
// Flush beats push and pop; a push on full without a pop is dropped (callers hold credits).
module kamus_fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type T = logic [63:0]
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  T                             wdata,
  output T                             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/kamus_fetch_unit.sv
// Pipelined fetch front end: PC gen, credit-limited L1I requests, prefetch FIFO to ID.
// rvalid at t -> instr_valid_o at t+1; requests stop when outstanding + buffered reaches FIFO_DEPTH.
module kamus_fetch_unit
  import kamus_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_data_o,
  output logic [31:0] instr_pc_o,
  output logic [31:0] instr_next_pc_o
);

  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e   state_q, state_d;
  logic [31:0]    fetch_pc_q, resp_pc_q, redirect_pc;
  logic [CW-1:0]  outstanding_q, outstanding_d, discard_q, discard_d;
  logic [31:0]    credit_used;
  logic           gnt_fire, push, pop;
  logic           fifo_full, fifo_empty;
  logic [FCW-1:0] fifo_count;
  fetch_entry_t   head, wentry;

  assign redirect_pc = {redirect_addr_i[31:2], 2'b00};
  assign credit_used = 32'(outstanding_q) + 32'(fifo_count);
  assign gnt_fire    = imem_req_o && imem_gnt_i;
  assign push        = imem_rvalid_i && (state_q == RUN_ST) && !redirect_i;
  assign pop         = instr_valid_o && instr_ready_i && !redirect_i;
  assign wentry      = '{instr: imem_rdata_i, pc: resp_pc_q};

  assign outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(imem_rvalid_i);

  // Every response owed at a redirect belongs to the old path and must be dropped.
  always_comb begin
    discard_d = discard_q;
    if (redirect_i)
      discard_d = outstanding_d;
    else if (state_q == DRAIN_ST && imem_rvalid_i)
      discard_d = discard_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= BOOT_ST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT_ST:  state_d = RUN_ST;
      RUN_ST:   state_d = (redirect_i && discard_d != '0) ? DRAIN_ST : RUN_ST;
      DRAIN_ST: state_d = (discard_d == '0) ? RUN_ST : DRAIN_ST;
      default:  state_d = BOOT_ST;
    endcase
  end

  always_comb begin
    imem_req_o = (state_q == RUN_ST)
              && (32'(outstanding_q) < MAX_OUTSTANDING)
              && (credit_used < FIFO_DEPTH)
              && !redirect_i;
  end

  assign imem_addr_o = fetch_pc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q    <= BOOT_ADDR;
      resp_pc_q     <= BOOT_ADDR;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      if (redirect_i) begin
        fetch_pc_q <= redirect_pc;
        resp_pc_q  <= redirect_pc;
      end else begin
        if (gnt_fire) fetch_pc_q <= fetch_pc_q + 32'(INSTR_BYTES);
        if (push)     resp_pc_q  <= resp_pc_q + 32'(INSTR_BYTES);
      end
    end
  end

  kamus_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .wdata (wentry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!(push && fifo_full && !pop)) else $error("prefetch FIFO overflow");
  end

  // With the buffer empty the PC outputs show the next PC to be delivered.
  assign instr_valid_o   = !fifo_empty;
  assign instr_data_o    = fifo_empty ? 32'h0 : head.instr;
  assign instr_pc_o      = fifo_empty ? resp_pc_q : head.pc;
  assign instr_next_pc_o = instr_pc_o + 32'(INSTR_BYTES);

endmodule
